// File: rtl/minmax_frame_tracker.sv
// Frame statistics tracker: groups N unsigned samples per frame and reports
// max/min (first-occurrence indices) and a non-decreasing flag, held until accepted.
module minmax_frame_tracker #(
  parameter int W = 4,
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_max,
  output logic [W-1:0]          out_min,
  output logic [$clog2(N)-1:0]  out_max_idx,
  output logic [$clog2(N)-1:0]  out_min_idx,
  output logic                  out_mono
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e          state_r;
  logic [IW-1:0]   cnt_r;
  logic [W-1:0]    run_max_r, run_min_r, prev_r;
  logic [IW-1:0]   max_idx_r, min_idx_r;
  logic            mono_r;
  logic            in_ready_r, out_valid_r;
  logic [W-1:0]    out_max_r, out_min_r;
  logic [IW-1:0]   out_max_idx_r, out_min_idx_r;
  logic            out_mono_r;

  logic [W-1:0]    nxt_max_s, nxt_min_s;
  logic [IW-1:0]   nxt_max_idx_s, nxt_min_idx_s;
  logic            nxt_mono_s;
  logic            accept_s;
  logic            last_s;

  assign accept_s = in_valid & in_ready_r;
  assign last_s   = (cnt_r == IW'(N - 1));

  // Running statistics including the sample offered this cycle.
  always_comb begin
    nxt_max_s     = run_max_r;
    nxt_min_s     = run_min_r;
    nxt_max_idx_s = max_idx_r;
    nxt_min_idx_s = min_idx_r;
    nxt_mono_s    = mono_r;
    if (cnt_r == IW'(0)) begin
      nxt_max_s     = in_data;
      nxt_min_s     = in_data;
      nxt_max_idx_s = IW'(0);
      nxt_min_idx_s = IW'(0);
      nxt_mono_s    = 1'b1;
    end else begin
      // Strict compares so ties keep the earlier index.
      if (in_data > run_max_r) begin
        nxt_max_s     = in_data;
        nxt_max_idx_s = cnt_r;
      end else begin
        nxt_max_s     = run_max_r;
        nxt_max_idx_s = max_idx_r;
      end
      if (in_data < run_min_r) begin
        nxt_min_s     = in_data;
        nxt_min_idx_s = cnt_r;
      end else begin
        nxt_min_s     = run_min_r;
        nxt_min_idx_s = min_idx_r;
      end
      if (in_data < prev_r) begin
        nxt_mono_s = 1'b0;
      end else begin
        nxt_mono_s = mono_r;
      end
    end
  end

  // Collect/hold FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= COLLECT;
      cnt_r         <= IW'(0);
      run_max_r     <= W'(0);
      run_min_r     <= W'(0);
      prev_r        <= W'(0);
      max_idx_r     <= IW'(0);
      min_idx_r     <= IW'(0);
      mono_r        <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      out_max_r     <= W'(0);
      out_min_r     <= W'(0);
      out_max_idx_r <= IW'(0);
      out_min_idx_r <= IW'(0);
      out_mono_r    <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            run_max_r <= nxt_max_s;
            run_min_r <= nxt_min_s;
            max_idx_r <= nxt_max_idx_s;
            min_idx_r <= nxt_min_idx_s;
            mono_r    <= nxt_mono_s;
            prev_r    <= in_data;
            if (last_s) begin
              cnt_r         <= IW'(0);
              state_r       <= HOLD;
              in_ready_r    <= 1'b0;
              out_valid_r   <= 1'b1;
              out_max_r     <= nxt_max_s;
              out_min_r     <= nxt_min_s;
              out_max_idx_r <= nxt_max_idx_s;
              out_min_idx_r <= nxt_min_idx_s;
              out_mono_r    <= nxt_mono_s;
            end else begin
              cnt_r <= cnt_r + IW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r     <= COLLECT;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= COLLECT;
          cnt_r       <= IW'(0);
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_max     = out_max_r;
  assign out_min     = out_min_r;
  assign out_max_idx = out_max_idx_r;
  assign out_min_idx = out_min_idx_r;
  assign out_mono    = out_mono_r;

endmodule

// File: tb/tb_minmax_frame_tracker.sv
// Self-checking bench for minmax_frame_tracker: directed frames with literal
// expectations plus randomized traffic against a frame-level reference model.
module tb_minmax_frame_tracker;
  localparam int W  = 4;
  localparam int N  = 8;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max, out_min;
  logic [IW-1:0] out_max_idx, out_min_idx;
  logic          out_mono;

  minmax_frame_tracker #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min),
    .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
    .out_mono(out_mono)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: collected samples of the open frame plus the last result.
  bit  m_hold;
  int  m_frame[$];
  int  m_max, m_min, m_max_idx, m_min_idx, m_mono;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_frame();
    int mx, mn;
    mx = m_frame[0];
    mn = m_frame[0];
    foreach (m_frame[i]) begin
      if (m_frame[i] > mx) mx = m_frame[i];
      if (m_frame[i] < mn) mn = m_frame[i];
    end
    m_max_idx = -1;
    m_min_idx = -1;
    foreach (m_frame[i]) begin
      if (m_max_idx < 0 && m_frame[i] == mx) m_max_idx = i;
      if (m_min_idx < 0 && m_frame[i] == mn) m_min_idx = i;
    end
    m_mono = 1;
    for (int i = 1; i < N; i++) if (m_frame[i] < m_frame[i-1]) m_mono = 0;
    m_max = mx;
    m_min = mn;
    m_hold = 1'b1;
    m_frame.delete();
  endtask

  task automatic model_edge();
    if (rst) begin
      m_hold = 1'b0;
      m_frame.delete();
      m_max = 0; m_min = 0; m_max_idx = 0; m_min_idx = 0; m_mono = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_frame.push_back(int'(in_data));
        if (m_frame.size() == N) finish_frame();
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic compare();
    chk("in_ready",    in_ready,    {31'd0, !m_hold});
    chk("out_valid",   out_valid,   {31'd0, m_hold});
    chk("out_max",     out_max,     m_max);
    chk("out_min",     out_min,     m_min);
    chk("out_max_idx", out_max_idx, m_max_idx);
    chk("out_min_idx", out_min_idx, m_min_idx);
    chk("out_mono",    out_mono,    m_mono);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Drive one frame; gapped mode drops in_valid every other cycle.
  task automatic send_frame(input int vals[N], input bit gapped);
    int i = 0;
    int cyc = 0;
    while (i < N && cyc < 4*N) begin
      in_valid = gapped ? cyc[0] : 1'b1;
      in_data  = in_valid ? W'(vals[i]) : W'($urandom);
      if (in_valid && !m_hold) i++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (i < N) begin
      checks++;
      failures++;
      $display("FAIL send_frame timeout: accepted %0d required %0d", i, N);
    end
  endtask

  task automatic pin(input string tag, input int mx, input int mxi, input int mn, input int mni, input int mo);
    chk({tag, "_valid"},   out_valid,   1);
    chk({tag, "_max"},     out_max,     mx);
    chk({tag, "_max_idx"}, out_max_idx, mxi);
    chk({tag, "_min"},     out_min,     mn);
    chk({tag, "_min_idx"}, out_min_idx, mni);
    chk({tag, "_mono"},    out_mono,    mo);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_max", out_max, 0);

    send_frame('{3, 7, 1, 7, 0, 9, 9, 2}, 1'b0);
    pin("f1", 9, 5, 0, 4, 0);
    release_result();

    send_frame('{0, 1, 1, 2, 5, 5, 14, 15}, 1'b0);
    pin("f2", 15, 7, 0, 0, 1);
    release_result();

    send_frame('{6, 6, 6, 6, 6, 6, 6, 6}, 1'b0);
    pin("f3", 6, 0, 6, 0, 1);

    // Back-pressure: upstream keeps offering, nothing may be consumed.
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data = W'($urandom);
      tick();
    end
    chk("bp_in_ready", in_ready, 0);
    pin("bp", 6, 0, 6, 0, 1);
    in_valid = 1'b0;
    release_result();
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_out_valid", out_valid, 0);

    send_frame('{15, 13, 11, 9, 7, 5, 3, 0}, 1'b1);
    pin("gap", 15, 0, 0, 7, 0);
    release_result();

    // Partial frame of 9s is discarded by reset.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = W'(9);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_frame('{2, 2, 2, 2, 2, 2, 2, 1}, 1'b0);
    pin("rstmid", 2, 0, 1, 7, 0);

    // Reset while holding a result.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsthold_out_valid", out_valid, 0);
    chk("rsthold_in_ready", in_ready, 1);
    chk("rsthold_max", out_max, 0);
    chk("rsthold_min", out_min, 0);
    chk("rsthold_max_idx", out_max_idx, 0);
    chk("rsthold_min_idx", out_min_idx, 0);
    chk("rsthold_mono", out_mono, 0);

    // Randomized traffic; small value range some of the time to force ties.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = (c[9]) ? W'($urandom_range(0, 2)) : W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
